// File: rtl/delay_frame_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : delay_frame_scheduler
// Purpose  : Per-sample frame sequencer for the delay core. Each accepted
//            sample tick runs four serial-bus transactions in fixed order
//            (ADC capture, SRAM write, SRAM read, DAC update). Every engine
//            gets a one-cycle start strobe, and the sequencer waits for that
//            engine's done before moving on. The block also owns the circular
//            delay-line pointers and drives the SRAM address.
// Options  : SCHED_TIMEOUT_EN - adds a per-phase watchdog. A phase that has
//            not seen done after TIMEOUT cycles aborts the frame and sets
//            o_err. When the macro is undefined, o_err is tied low.
// Ports    : clk        system clock, rising edge
//            rst        synchronous active-high reset
//            i_tick     sample strobe, one cycle wide
//            i_delay    delay length in samples, latched on an accepted tick
//            i_done     per-engine done: [0] ADC [1] SRAM wr [2] SRAM rd [3] DAC
//            o_start    one-hot, one-cycle start strobes for the same engines
//            o_addr     SRAM address (write pointer in WR, delayed pointer in RD)
//            o_busy     high whenever a frame is in progress
//            o_overrun  sticky: a tick arrived while busy and was dropped
//            o_err      sticky: a phase timed out
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module delay_frame_scheduler #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic [ADDR_W-1:0] i_delay,
    input  logic [3:0]        i_done,
    output logic [3:0]        o_start,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADC  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DAC  = 3'd4
    } state_t;

    // One counter serves both the done-sampling window and the watchdog.
    localparam int c_CW = ($clog2(TIMEOUT + 1) < 2) ? 2 : $clog2(TIMEOUT + 1);
`ifdef SCHED_TIMEOUT_EN
    localparam int c_CMAX = TIMEOUT - 1;
`else
    localparam int c_CMAX = 2;
`endif

    state_t            r_state;
    logic [c_CW-1:0]   r_cyc;       // cycles elapsed in the current phase
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_dly;
    logic [3:0]        r_start;
    logic [ADDR_W-1:0] r_addr;
    logic              r_overrun;

    logic              w_done_sel;
    logic              w_done;
    logic              w_tmo;
    logic [ADDR_W-1:0] w_rd_addr;

    // Only the active phase's done bit is observed.
    always_comb begin
        w_done_sel = 1'b0;
        case (r_state)
            S_ADC:   w_done_sel = i_done[0];
            S_WR:    w_done_sel = i_done[1];
            S_RD:    w_done_sel = i_done[2];
            S_DAC:   w_done_sel = i_done[3];
            default: w_done_sel = 1'b0;
        endcase
    end

    // done is ignored in the start cycle and the one after it, so engines that
    // idle with done high have two cycles to drop it.
    assign w_done    = w_done_sel && (r_cyc >= c_CW'(2));
    assign w_rd_addr = r_wr_ptr - r_dly;   // natural wrap gives mod 2**ADDR_W

`ifdef SCHED_TIMEOUT_EN
    logic r_err;
    assign w_tmo = (r_cyc == c_CW'(c_CMAX)) && !w_done;
    assign o_err = r_err;
`else
    assign w_tmo = 1'b0;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_wr_ptr  <= '0;
            r_dly     <= '0;
            r_start   <= 4'b0000;
            r_addr    <= '0;
            r_overrun <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_start <= 4'b0000;

            if (i_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_addr <= '0;
                if (i_tick) begin
                    r_state <= S_ADC;
                    r_start <= 4'b0001;
                    r_cyc   <= '0;
                    r_dly   <= i_delay;
                end
            end else if (w_done) begin
                r_cyc <= '0;
                case (r_state)
                    S_ADC: begin
                        r_state <= S_WR;
                        r_start <= 4'b0010;
                        r_addr  <= r_wr_ptr;
                    end
                    S_WR: begin
                        r_state <= S_RD;
                        r_start <= 4'b0100;
                        r_addr  <= w_rd_addr;
                    end
                    S_RD: begin
                        r_state <= S_DAC;
                        r_start <= 4'b1000;
                        r_addr  <= '0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_addr   <= '0;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                endcase
            end else if (w_tmo) begin
                // Aborted frame: pointer deliberately left unchanged.
                r_state <= S_IDLE;
                r_cyc   <= '0;
                r_addr  <= '0;
`ifdef SCHED_TIMEOUT_EN
                r_err   <= 1'b1;
`endif
            end else if (r_cyc != c_CW'(c_CMAX)) begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    assign o_start   = r_start;
    assign o_addr    = r_addr;
    assign o_busy    = (r_state != S_IDLE);
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire
